// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - operand forwarding and load-use hazard unit for the 5-stage pipeline
// Optional FWD_STATS_EN macro enables the forward/stall event counters.
module operand_bypass_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_RD     = 2,
    parameter int STAGES     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic                         issue_wen,
    input  logic                         issue_load,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    input  logic                         flush,
    input  logic [XLEN-1:0]              ex_result,
    input  logic [XLEN-1:0]              mem_rdata,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rs_addr,
    input  logic [NUM_RD*XLEN-1:0]       rf_rdata,
    output logic [NUM_RD*XLEN-1:0]       fwd_data,
    output logic [NUM_RD-1:0]            fwd_hit,
    output logic                         stall,
    output logic [31:0]                  fwd_count,
    output logic [31:0]                  stall_count
);

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
        logic                  dvalid;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t ents_q [STAGES];
    entry_t ents_d [STAGES];

    logic [XLEN-1:0]        live     [STAGES];
    logic                   fwdable  [STAGES];
    logic [NUM_RD*XLEN-1:0] fwd_data_c;
    logic [NUM_RD-1:0]      fwd_hit_c;
    logic [NUM_RD-1:0]      load_use;
    logic                   stall_c;

    // Values still in flight on the EX/MEM buses are taken live rather than from storage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            live[k]    = ents_q[k].data;
            fwdable[k] = ents_q[k].dvalid;
        end
        live[0]    = ex_result;
        fwdable[0] = !ents_q[0].load;
        if (ents_q[1].load) begin
            live[1]    = mem_rdata;
            fwdable[1] = 1'b1;
        end
    end

    // Scan oldest to youngest so the youngest matching entry overwrites older ones.
    always_comb begin
        fwd_data_c = rf_rdata;
        fwd_hit_c  = '0;
        load_use   = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (ents_q[k].valid && ents_q[k].wen &&
                    ents_q[k].rd == rs_addr[p*REG_ADDR_W +: REG_ADDR_W] &&
                    rs_addr[p*REG_ADDR_W +: REG_ADDR_W] != '0) begin
                    fwd_hit_c[p]                = fwdable[k];
                    load_use[p]                 = !fwdable[k];
                    fwd_data_c[p*XLEN +: XLEN]  = fwdable[k] ? live[k] : rf_rdata[p*XLEN +: XLEN];
                end
            end
        end
        stall_c = issue_valid && !flush && (|load_use);
    end

    always_comb begin
        ents_d[0] = '0;
        if (issue_valid && !stall_c && !flush) begin
            ents_d[0].valid = 1'b1;
            ents_d[0].wen   = issue_wen;
            ents_d[0].load  = issue_load;
            ents_d[0].rd    = issue_rd;
        end

        ents_d[1] = ents_q[0];
        if (flush) begin
            ents_d[1] = '0;
        end else if (ents_q[0].valid && !ents_q[0].load) begin
            ents_d[1].data   = ex_result;
            ents_d[1].dvalid = 1'b1;
        end

        for (int k = 1; k < STAGES - 1; k++) begin
            ents_d[k+1] = ents_q[k];
        end
        if (ents_q[1].load) begin
            ents_d[2].data   = mem_rdata;
            ents_d[2].dvalid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) ents_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) ents_q[k] <= ents_d[k];
        end
    end

    assign fwd_data = fwd_data_c;
    assign fwd_hit  = fwd_hit_c;
    assign stall    = stall_c;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_count_q, fwd_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] pop;
    logic [32:0] fsum;

    // Both counters saturate instead of wrapping.
    always_comb begin
        pop = '0;
        for (int p = 0; p < NUM_RD; p++) pop = pop + 32'(fwd_hit_c[p]);
        fsum          = {1'b0, fwd_count_q} + {1'b0, pop};
        fwd_count_d   = fwd_count_q;
        stall_count_d = stall_count_q;
        if (issue_valid && !stall_c) fwd_count_d = fsum[32] ? '1 : fsum[31:0];
        if (stall_c && stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            fwd_count_q   <= fwd_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`else
    assign fwd_count   = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// tb/tb_operand_bypass_unit.sv - directed and random checks of operand_bypass_unit against a queue-based model
module tb_operand_bypass_unit;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int NRD  = 2;
    localparam int STG  = 3;
`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst, issue_valid, issue_wen, issue_load, flush;
    logic [RW-1:0]       issue_rd;
    logic [XLEN-1:0]     ex_result, mem_rdata;
    logic [NRD*RW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rf_rdata, fwd_data;
    logic [NRD-1:0]      fwd_hit;
    logic                stall;
    logic [31:0]         fwd_count, stall_count;

    operand_bypass_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .NUM_RD(NRD), .STAGES(STG)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_load(issue_load), .issue_rd(issue_rd), .flush(flush),
        .ex_result(ex_result), .mem_rdata(mem_rdata), .rs_addr(rs_addr),
        .rf_rdata(rf_rdata), .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall),
        .fwd_count(fwd_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // In-flight instructions, youngest first; age 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        logic          wen;
        logic          load;
        logic [RW-1:0] rd;
        logic [31:0]   val;
        int            age;
    } mi_t;
    mi_t q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [NRD*XLEN-1:0] exp_data;
    logic [NRD-1:0]      exp_hit;
    logic                exp_stall;
    logic [31:0]         exp_fc = 0, exp_sc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_eval();
        logic haz;
        logic found;
        logic [RW-1:0] rs;
        exp_data = rf_rdata;
        exp_hit  = '0;
        haz      = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            rs    = rs_addr[p*RW +: RW];
            found = 1'b0;
            if (rs != 0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (!found && q[i].wen && q[i].rd == rs) begin
                        found = 1'b1;
                        if (q[i].age == 0 && q[i].load) begin
                            haz = 1'b1;
                        end else begin
                            exp_hit[p] = 1'b1;
                            if (q[i].age == 0)                    exp_data[p*XLEN +: XLEN] = ex_result;
                            else if (q[i].age == 1 && q[i].load)  exp_data[p*XLEN +: XLEN] = mem_rdata;
                            else                                  exp_data[p*XLEN +: XLEN] = q[i].val;
                        end
                    end
                end
            end
        end
        exp_stall = issue_valid && !flush && haz;
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("fwd_data", fwd_data, exp_data);
        chk("fwd_hit", fwd_hit, exp_hit);
        chk("stall", stall, exp_stall);
        chk("fwd_count", fwd_count, exp_fc);
        chk("stall_count", stall_count, exp_sc);
    endtask

    task automatic advance();
        mi_t n;
        int  pc;
        if (rst) begin
            q.delete();
            exp_fc = 0;
            exp_sc = 0;
        end else begin
            if (STATS) begin
                pc = 0;
                for (int p = 0; p < NRD; p++) pc += int'(exp_hit[p]);
                if (issue_valid && !exp_stall)
                    exp_fc = (64'(exp_fc) + 64'(pc) > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : exp_fc + 32'(pc);
                if (exp_stall && exp_sc != 32'hFFFF_FFFF) exp_sc++;
            end
            if (flush && q.size() > 0 && q[0].age == 0) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].age == 0 && !q[i].load) q[i].val = ex_result;
                if (q[i].age == 1 && q[i].load)  q[i].val = mem_rdata;
                q[i].age++;
            end
            while (q.size() > 0 && q[q.size()-1].age >= STG) void'(q.pop_back());
            if (issue_valid && !exp_stall && !flush) begin
                n.wen = issue_wen; n.load = issue_load; n.rd = issue_rd; n.val = 0; n.age = 0;
                q.push_front(n);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_issue(input logic v, input logic w, input logic ld, input logic [RW-1:0] rd);
        issue_valid = v; issue_wen = w; issue_load = ld; issue_rd = rd;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        set_issue(0, 0, 0, 0);
        ex_result = 0; mem_rdata = 0; rs_addr = 0; rf_rdata = 0;
        @(negedge clk);
        settle(); advance();
        rst = 1'b0;

        // Reset state: regfile passthrough
        rs_addr = {5'd2, 5'd1}; rf_rdata = {32'hB, 32'hA};
        settle();
        chk("rst_data", fwd_data, {32'hB, 32'hA});
        chk("rst_hit", fwd_hit, 2'b00);
        chk("rst_stall", stall, 1'b0);
        advance();

        // ALU forward from EX
        set_issue(1, 1, 0, 5'd5); settle(); advance();
        set_issue(0, 0, 0, 0); rs_addr = {5'd2, 5'd5}; ex_result = 32'h1234;
        settle();
        chk("ex_fwd_data", fwd_data[31:0], 32'h1234);
        chk("ex_fwd_hit", fwd_hit[0], 1'b1);
        advance();

        // Load-use: one stall, then MEM forward
        set_issue(1, 1, 1, 5'd6); settle(); advance();
        set_issue(1, 1, 0, 5'd9); rs_addr = {5'd6, 5'd0};
        settle();
        chk("lu_stall", stall, 1'b1);
        advance();
        mem_rdata = 32'hCAFE;
        settle();
        chk("lu_mem_data", fwd_data[63:32], 32'hCAFE);
        chk("lu_mem_hit", fwd_hit[1], 1'b1);
        chk("lu_stall_off", stall, 1'b0);
        advance();

        // Youngest of two writers of x7
        set_issue(1, 1, 0, 5'd7); settle(); advance();
        ex_result = 32'h1; settle(); advance();
        set_issue(0, 0, 0, 0); ex_result = 32'h2; rs_addr = {5'd1, 5'd7};
        settle();
        chk("young_data", fwd_data[31:0], 32'h2);
        advance();

        // x0 never forwards
        set_issue(1, 1, 0, 5'd0); settle(); advance();
        set_issue(0, 0, 0, 0); ex_result = 32'h55; rs_addr = {5'd1, 5'd0}; rf_rdata = {32'h11, 32'h77};
        settle();
        chk("x0_data", fwd_data[31:0], 32'h77);
        chk("x0_hit", fwd_hit[0], 1'b0);
        advance();

        // Flush during load-use suppresses stall and kills the load
        set_issue(1, 1, 1, 5'd6); settle(); advance();
        set_issue(1, 1, 0, 5'd8); rs_addr = {5'd6, 5'd0}; flush = 1'b1;
        settle();
        chk("flush_stall", stall, 1'b0);
        advance();
        flush = 1'b0; set_issue(0, 0, 0, 0); rf_rdata = {32'h66, 32'h0};
        settle();
        chk("flush_kill_hit", fwd_hit[1], 1'b0);
        chk("flush_kill_data", fwd_data[63:32], 32'h66);
        advance();

        // Reset mid-stream drops in-flight writes
        set_issue(1, 1, 0, 5'd3); settle(); advance();
        set_issue(0, 0, 0, 0); rst = 1'b1; rs_addr = {5'd0, 5'd3};
        settle(); advance();
        rst = 1'b0;
        settle();
        chk("rst_mid_hit", fwd_hit, 2'b00);
        advance();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                      $urandom_range(0, 2) == 0, RW'($urandom_range(0, 7)));
            ex_result  = $urandom();
            mem_rdata  = $urandom();
            rs_addr    = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
            rf_rdata   = {$urandom(), $urandom()};
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
